// File: rtl/zap_uart_stim_pkg.sv
// zap_uart_stim_pkg
//   Shared types and helpers for the zap UART stimulus generator.
//   - lane_state_e : per-lane serialiser state
//   - PARITY_BITS  : 1 when ZAP_UART_STIM_PARITY_EN is defined, else 0
//   - frame_bits() : bit periods per frame
//   - timer_w()    : counter width able to hold 0..cycles-1
//   - even_parity(): XOR of the low nbits of a byte
package zap_uart_stim_pkg;

  typedef enum logic [2:0] {
    ST_GUARD  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } lane_state_e;

`ifdef ZAP_UART_STIM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_bits(input int data_bits, input int stop_bits);
    return 1 + data_bits + PARITY_BITS + stop_bits;
  endfunction

  function automatic int timer_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic logic even_parity(input logic [7:0] data, input int nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (data[i] & (i < nbits));
    end
    return p;
  endfunction

endpackage

// File: rtl/zap_uart_stim_lane.sv
// zap_uart_stim_lane
//   One UART lane: byte FIFO, frame FSM and LSB-first shifter.
//   Optional even-parity bit when ZAP_UART_STIM_PARITY_EN is defined.
// Ports
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_guard_done     shared power-up guard has expired
//   i_push           write i_push_data into the FIFO (already qualified by ready)
//   i_push_data      byte to queue
//   o_ready          FIFO not full (combinational)
//   o_uart           serial line, idle high (registered)
//   o_busy           FIFO non-empty or frame in flight (registered)
//   o_frame_done     pulse on the last stop-bit cycle (registered)
module zap_uart_stim_lane
  import zap_uart_stim_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_guard_done,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  output logic       o_ready,
  output logic       o_uart,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int STOP_CYC = STOP_BITS * CLKS_PER_BIT;
  localparam int TW       = timer_w(STOP_CYC);
  localparam logic [TW-1:0] BIT_TERM  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_TERM = TW'(STOP_CYC - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  lane_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_q, uart_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
`ifdef ZAP_UART_STIM_PARITY_EN
  logic          parity_q, parity_d;
`endif
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic          empty_s, full_s, pop_s, push_ok_s;
  logic [7:0]    head_s;

  // FIFO status: pointers carry one extra wrap bit so full and empty differ.
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_ok_s = i_push & ~full_s;
    head_s    = fifo_mem[rd_ptr_q[AW-1:0]];
    o_ready   = ~full_s;
  end

  // Frame FSM next-state; a pop happens from IDLE or straight out of the final stop cycle.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
`ifdef ZAP_UART_STIM_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_GUARD: begin
        if (i_guard_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_START;
          timer_d = TW'(0);
          shift_d = head_s;
`ifdef ZAP_UART_STIM_PARITY_EN
          parity_d = even_parity(head_s, DATA_BITS);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_q == BIT_TERM) begin
          state_d   = ST_DATA;
          timer_d   = TW'(0);
          bit_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_TERM) begin
          timer_d = TW'(0);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef ZAP_UART_STIM_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_PARITY: begin
        if (timer_q == BIT_TERM) begin
          state_d = ST_STOP;
          timer_d = TW'(0);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (timer_q == STOP_TERM) begin
          timer_d = TW'(0);
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_START;
            shift_d = head_s;
`ifdef ZAP_UART_STIM_PARITY_EN
            parity_d = even_parity(head_s, DATA_BITS);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_GUARD;
        timer_d = TW'(0);
      end
    endcase

    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok_s);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_s);
  end

  // Outputs are derived from next-state values so the registered line tracks the state exactly.
  always_comb begin
    case (state_d)
      ST_START: uart_d = 1'b0;
      ST_DATA:  uart_d = shift_d[0];
`ifdef ZAP_UART_STIM_PARITY_EN
      ST_PARITY: uart_d = parity_d;
`else
      ST_PARITY: uart_d = 1'b1;
`endif
      default:  uart_d = 1'b1;
    endcase
    frame_done_d = (state_d == ST_STOP) && (timer_d == STOP_TERM);
    busy_d       = (wr_ptr_d != rd_ptr_d) || ((state_d != ST_IDLE) && (state_d != ST_GUARD));
  end

  // State registers; reset drives the line high immediately and discards queued bytes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_GUARD;
      timer_q      <= TW'(0);
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      uart_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= (AW+1)'(0);
      rd_ptr_q     <= (AW+1)'(0);
`ifdef ZAP_UART_STIM_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      uart_q       <= uart_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
`ifdef ZAP_UART_STIM_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written, validity lives in the pointers.
  always_ff @(posedge i_clk) begin
    if (push_ok_s) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= i_push_data;
    end
  end

  assign o_uart       = uart_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: rtl/zap_uart_stim_gen.sv
// zap_uart_stim_gen
//   Multi-channel UART frame generator for the zap test harness. Holds the
//   push decoder, the shared power-up guard counter and the sticky overflow
//   flag; one zap_uart_stim_lane per channel does the framing.
//   Build option: define ZAP_UART_STIM_PARITY_EN to add an even-parity bit.
// Ports
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_push_valid     push request
//   i_push_ch        target lane
//   i_push_data      byte; bits above DATA_BITS are ignored
//   o_push_ready     selected lane can accept (combinational on i_push_ch)
//   o_uart           serial lines, idle high
//   o_busy           per-lane FIFO data or frame in flight
//   o_frame_done     per-lane pulse on the last stop-bit cycle
//   o_overflow       sticky: a push was dropped
module zap_uart_stim_gen
  import zap_uart_stim_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CH_W         = 1,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_BITS    = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push_valid,
  input  logic [CH_W-1:0]   i_push_ch,
  input  logic [7:0]        i_push_data,
  output logic              o_push_ready,
  output logic [NUM_CH-1:0] o_uart,
  output logic [NUM_CH-1:0] o_busy,
  output logic [NUM_CH-1:0] o_frame_done,
  output logic              o_overflow
);

  localparam int GUARD_CYC = IDLE_BITS * CLKS_PER_BIT;
  localparam int GW        = $clog2(GUARD_CYC + 2);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [GW-1:0]         guard_q, guard_d;
  logic                  overflow_q, overflow_d;
  logic                  guard_done_s;
  logic                  ch_ok_s, push_ready_s;
  logic [NUM_CH-1:0]     lane_ready_s, push_s;
  logic [(1<<CH_W)-1:0]  ready_pad_s;

  // Push decode; out-of-range channels are never ready, so their pushes count as overflow.
  always_comb begin
    ready_pad_s = {(1<<CH_W){1'b0}};
    ready_pad_s[NUM_CH-1:0] = lane_ready_s;
    ch_ok_s = ({1'b0, i_push_ch} < NUM_CH_L);
    if (ch_ok_s) begin
      push_ready_s = ready_pad_s[i_push_ch];
    end else begin
      push_ready_s = 1'b0;
    end
    for (int g = 0; g < NUM_CH; g++) begin
      push_s[g] = i_push_valid & push_ready_s & (i_push_ch == CH_W'(g));
    end
    overflow_d   = overflow_q | (i_push_valid & ~push_ready_s);
    guard_done_s = (guard_q == GW'(0));
    if (guard_done_s) begin
      guard_d = guard_q;
    end else begin
      guard_d = guard_q - GW'(1);
    end
  end

  // Guard counter and overflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      guard_q    <= GW'(GUARD_CYC);
      overflow_q <= 1'b0;
    end else begin
      guard_q    <= guard_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    zap_uart_stim_lane #(
      .DATA_BITS    (DATA_BITS),
      .STOP_BITS    (STOP_BITS),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_lane (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_guard_done (guard_done_s),
      .i_push       (push_s[g]),
      .i_push_data  (i_push_data),
      .o_ready      (lane_ready_s[g]),
      .o_uart       (o_uart[g]),
      .o_busy       (o_busy[g]),
      .o_frame_done (o_frame_done[g])
    );
  end

  assign o_push_ready = push_ready_s;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_zap_uart_stim_gen.sv
// Bench for zap_uart_stim_gen. A line receiver decodes every lane by
// mid-bit sampling and checks o_frame_done placement; the tests compare
// decoded bytes, timing and flags against values computed from the frame rules.
module tb_zap_uart_stim_gen;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int DB     = 8;
  localparam int SB     = 1;
  localparam int CPB    = 16;
  localparam int DEPTH  = 16;
  localparam int IDLE_BITS = 255;
`ifdef ZAP_UART_STIM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_CYC = (1 + DB + PAR + SB) * CPB;
  localparam int GUARD_CYC = IDLE_BITS * CPB;

  logic              clk;
  logic              i_reset;
  logic              i_push_valid;
  logic [CH_W-1:0]   i_push_ch;
  logic [7:0]        i_push_data;
  logic              o_push_ready;
  logic [NUM_CH-1:0] o_uart;
  logic [NUM_CH-1:0] o_busy;
  logic [NUM_CH-1:0] o_frame_done;
  logic              o_overflow;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  zap_uart_stim_gen #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_BITS(DB), .STOP_BITS(SB),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_push_valid(i_push_valid),
    .i_push_ch(i_push_ch), .i_push_data(i_push_data), .o_push_ready(o_push_ready),
    .o_uart(o_uart), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: decoded bytes, frame start cycles and parity bits per lane.
  int         pos [NUM_CH];
  logic [7:0] acc [NUM_CH];
  logic [7:0] rx_q    [NUM_CH][$];
  longint     start_q [NUM_CH][$];
  logic       par_q   [NUM_CH][$];
  int         b;
  logic       want_fd;

  initial begin
    for (int l = 0; l < NUM_CH; l++) pos[l] = -1;
  end

  always @(negedge clk) begin
    for (int l = 0; l < NUM_CH; l++) begin
      if (i_reset) begin
        pos[l] = -1;
      end else if (pos[l] < 0) begin
        total++;
        if (o_frame_done[l] !== 1'b0) begin
          bad++;
          $display("FAIL frame_done_idle lane%0d: got %b want 0 at cycle %0d", l, o_frame_done[l], cyc);
        end
        if (o_uart[l] === 1'b0) begin
          pos[l] = 0;
          acc[l] = 8'h00;
          start_q[l].push_back(cyc);
        end
      end else begin
        pos[l] = pos[l] + 1;
        b = pos[l] / CPB;
        if ((pos[l] % CPB) == CPB / 2) begin
          if (b == 0) begin
            total++;
            if (o_uart[l] !== 1'b0) begin
              bad++;
              $display("FAIL start_bit lane%0d: got %b want 0", l, o_uart[l]);
            end
          end else if (b <= DB) begin
            acc[l][b-1] = o_uart[l];
          end
`ifdef ZAP_UART_STIM_PARITY_EN
          else if (b == DB + 1) begin
            par_q[l].push_back(o_uart[l]);
            total++;
            if (o_uart[l] !== ^acc[l]) begin
              bad++;
              $display("FAIL parity_bit lane%0d: got %b want %b", l, o_uart[l], ^acc[l]);
            end
          end
`endif
          else begin
            total++;
            if (o_uart[l] !== 1'b1) begin
              bad++;
              $display("FAIL stop_bit lane%0d: got %b want 1", l, o_uart[l]);
            end
          end
        end
        want_fd = (pos[l] == FRAME_CYC - 1);
        total++;
        if (o_frame_done[l] !== want_fd) begin
          bad++;
          $display("FAIL frame_done_pos lane%0d: got %b want %b at bit pos %0d", l, o_frame_done[l], want_fd, pos[l]);
        end
        if (want_fd) begin
          rx_q[l].push_back(acc[l]);
          pos[l] = -1;
        end
      end
    end
  end

  task automatic clear_rx();
    for (int l = 0; l < NUM_CH; l++) begin
      rx_q[l].delete();
      start_q[l].delete();
      par_q[l].delete();
    end
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    i_push_valid = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    clear_rx();
  endtask

  // Drive one push; rdy returns o_push_ready as seen just before the accepting edge.
  task automatic push_byte(input int ch, input logic [7:0] d, output logic rdy);
    @(negedge clk);
    i_push_valid = 1'b1;
    i_push_ch    = CH_W'(ch);
    i_push_data  = d;
    #1;
    rdy = o_push_ready;
    @(posedge clk);
    #1;
    i_push_valid = 1'b0;
  endtask

  task automatic test_reset();
    int errs;
    i_reset = 1'b1;
    i_push_valid = 1'b0;
    i_push_ch = '0;
    i_push_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (o_uart !== 2'b11 || o_busy !== 2'b00 || o_frame_done !== 2'b00 || o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: uart=%b busy=%b fd=%b ovf=%b want 11 00 00 0", o_uart, o_busy, o_frame_done, o_overflow);
    end
    i_reset = 1'b0;
    clear_rx();
    errs = 0;
    for (int i = 0; i < GUARD_CYC; i++) begin
      @(negedge clk);
      if (o_uart !== 2'b11 || o_busy !== 2'b00) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL guard_idle: %0d bad cycles, want 0", errs);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic rdy;
    int n;
    push_byte(0, 8'h48, rdy);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", rdy); end
    @(negedge clk);
    total++;
    if (o_uart[0] !== 1'b1 || o_busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_lat1: uart=%b busy=%b want 1 1", o_uart[0], o_busy[0]);
    end
    @(negedge clk);
    total++;
    if (o_uart[0] !== 1'b0) begin bad++; $display("FAIL single_lat2: uart=%b want 0", o_uart[0]); end
    n = 0;
    while (rx_q[0].size() < 1 && n < FRAME_CYC + 50) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (rx_q[0].size() != 1 || rx_q[0][0] !== 8'h48) begin
      bad++;
      $display("FAIL single_data: got %0d bytes first %h want 1 byte 48", rx_q[0].size(), (rx_q[0].size() > 0) ? rx_q[0][0] : 8'hxx);
    end
    total++;
    if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", o_busy[0]); end
    clear_rx();
  endtask

  task automatic test_back_to_back();
    string s = "DLROW OLLEH ";
    logic rdy;
    logic [7:0] c;
    int n, fd;
    for (int i = 0; i < 12; i++) begin
      c = s[i];
      push_byte(1, c, rdy);
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_ready idx%0d: got %b want 1", i, rdy); end
    end
    n = 0;
    fd = 0;
    while (fd < 12 && n < 12 * FRAME_CYC + 200) begin
      @(negedge clk);
      n++;
      if (o_frame_done[1] === 1'b1) fd++;
    end
    total++;
    if (fd != 12 || o_busy[1] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_last_frame: frames=%0d busy=%b want 12 1", fd, o_busy[1]);
    end
    @(negedge clk);
    total++;
    if (o_busy[1] !== 1'b0) begin bad++; $display("FAIL b2b_busy_fall: got %b want 0", o_busy[1]); end
    total++;
    if (rx_q[1].size() != 12) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 12", rx_q[1].size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        c = s[i];
        total++;
        if (rx_q[1][i] !== c) begin bad++; $display("FAIL b2b_char idx%0d: got %h want %h", i, rx_q[1][i], c); end
        if (i > 0) begin
          total++;
          if (start_q[1][i] - start_q[1][i-1] != FRAME_CYC) begin
            bad++;
            $display("FAIL b2b_gap idx%0d: got %0d want %0d", i, start_q[1][i] - start_q[1][i-1], FRAME_CYC);
          end
        end
      end
    end
    clear_rx();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic rdy;
    int n;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      push_byte(0, d, rdy);
      total++;
      if (rdy !== 1'b1) begin bad++; $display("FAIL ovf_fill_ready idx%0d: got %b want 1", i, rdy); end
    end
    total++;
    if (o_overflow !== 1'b0 || o_uart[0] !== 1'b1 || o_busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_before: ovf=%b uart=%b busy=%b want 0 1 1", o_overflow, o_uart[0], o_busy[0]);
    end
    push_byte(0, 8'hEE, rdy);
    total++;
    if (rdy !== 1'b0) begin bad++; $display("FAIL ovf_full_ready: got %b want 0", rdy); end
    total++;
    if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
    @(negedge clk);
    i_push_ch = 1'b1;
    #1;
    total++;
    if (o_push_ready !== 1'b1) begin bad++; $display("FAIL ovf_other_lane_ready: got %b want 1", o_push_ready); end
    n = 0;
    while (rx_q[0].size() < DEPTH && n < GUARD_CYC + DEPTH * FRAME_CYC + 500) begin @(negedge clk); n++; end
    repeat (FRAME_CYC + 20) @(negedge clk);
    total++;
    if (rx_q[0].size() != DEPTH) begin
      bad++;
      $display("FAIL ovf_frames: got %0d want %0d", rx_q[0].size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        total++;
        if (rx_q[0][i] !== exp_q[i]) begin bad++; $display("FAIL ovf_data idx%0d: got %h want %h", i, rx_q[0][i], exp_q[i]); end
      end
    end
    total++;
    if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
    clear_rx();
  endtask

  task automatic test_mid_frame_reset();
    logic rdy;
    int n;
    push_byte(0, 8'h00, rdy);
    push_byte(0, 8'h55, rdy);
    push_byte(0, 8'hA3, rdy);
    n = 0;
    while (o_uart[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (3 * CPB) @(negedge clk);
    total++;
    if (o_uart[0] !== 1'b0) begin bad++; $display("FAIL mid_pre_line: got %b want 0", o_uart[0]); end
    #2;
    i_reset = 1'b1;
    #1;
    total++;
    if (o_uart[0] !== 1'b1 || o_busy !== 2'b00) begin
      bad++;
      $display("FAIL mid_async_reset: uart=%b busy=%b want 1 00", o_uart[0], o_busy);
    end
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    clear_rx();
    repeat (GUARD_CYC + 2 * FRAME_CYC) @(negedge clk);
    total++;
    if (start_q[0].size() != 0 || rx_q[0].size() != 0 || o_busy[0] !== 1'b0 || o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: starts=%0d frames=%0d busy=%b ovf=%b want 0 0 0 0",
               start_q[0].size(), rx_q[0].size(), o_busy[0], o_overflow);
    end
    clear_rx();
  endtask

  task automatic test_random();
    logic [7:0] exp_q [NUM_CH][$];
    logic [7:0] d;
    logic rdy;
    int ch, cnt, n;
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < NUM_CH; l++) exp_q[l].delete();
      cnt = $urandom_range(5, 15);
      for (int i = 0; i < cnt; i++) begin
        ch = $urandom_range(0, NUM_CH - 1);
        d  = 8'($urandom_range(0, 255));
        exp_q[ch].push_back(d & 8'((1 << DB) - 1));
        push_byte(ch, d, rdy);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL rand_ready r%0d i%0d: got %b want 1", r, i, rdy); end
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      n = 0;
      while ((rx_q[0].size() < exp_q[0].size() || rx_q[1].size() < exp_q[1].size()) &&
             n < 16 * FRAME_CYC + 500) begin
        @(negedge clk);
        n++;
      end
      repeat (20) @(negedge clk);
      for (int l = 0; l < NUM_CH; l++) begin
        total++;
        if (rx_q[l].size() != exp_q[l].size()) begin
          bad++;
          $display("FAIL rand_count r%0d lane%0d: got %0d want %0d", r, l, rx_q[l].size(), exp_q[l].size());
        end else begin
          for (int i = 0; i < exp_q[l].size(); i++) begin
            total++;
            if (rx_q[l][i] !== exp_q[l][i]) begin
              bad++;
              $display("FAIL rand_data r%0d lane%0d idx%0d: got %h want %h", r, l, i, rx_q[l][i], exp_q[l][i]);
            end
          end
        end
      end
      total++;
      if (o_busy !== 2'b00) begin bad++; $display("FAIL rand_busy_end r%0d: got %b want 00", r, o_busy); end
      clear_rx();
    end
  endtask

`ifdef ZAP_UART_STIM_PARITY_EN
  task automatic test_parity();
    logic rdy;
    int n;
    push_byte(0, 8'h07, rdy);
    push_byte(0, 8'h03, rdy);
    n = 0;
    while (rx_q[0].size() < 2 && n < 3 * FRAME_CYC) begin @(negedge clk); n++; end
    @(negedge clk);
    total++;
    if (par_q[0].size() != 2 || rx_q[0].size() != 2) begin
      bad++;
      $display("FAIL parity_count: got %0d want 2", par_q[0].size());
    end else begin
      total++;
      if (par_q[0][0] !== 1'b1 || par_q[0][1] !== 1'b0) begin
        bad++;
        $display("FAIL parity_values: got %b %b want 1 0", par_q[0][0], par_q[0][1]);
      end
      total++;
      if (start_q[0][1] - start_q[0][0] != 11 * CPB) begin
        bad++;
        $display("FAIL parity_frame_len: got %0d want %0d", start_q[0][1] - start_q[0][0], 11 * CPB);
      end
    end
    clear_rx();
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
`ifdef ZAP_UART_STIM_PARITY_EN
    test_parity();
`endif
    test_overflow();
    test_mid_frame_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
